// File: rtl/alu_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multdiv_ctrl
//  Purpose  : Multi-cycle signed multiply / divide sequencer for the execute
//             stage. Multiply is radix-2 shift-add and divide is restoring.
//             Both run 32 iterations over one shared 33-bit add/subtract
//             datapath. A sign-fix cycle then produces the final result.
//  Ports    :
//    clock          - single clock, rising edge
//    reset_n        - asynchronous active-low reset
//    data_operandA  - multiplicand / dividend (two's complement), sampled on accept
//    data_operandB  - multiplier / divisor (two's complement), sampled on accept
//    ctrl_MULT      - start-multiply pulse (wins over ctrl_DIV)
//    ctrl_DIV       - start-divide pulse
//    data_result    - registered result, held until the next completion
//    data_exception - registered overflow / divide-by-zero flag
//    data_resultRDY - one-cycle completion pulse
//    busy           - high from the accepting edge through the completion edge
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multdiv_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q,     state_d;
  logic [4:0]  count_q,     count_d;
  // MUL: {partial product high, multiplier shifting out / product low}
  // DIV: {remainder, dividend shifting out / quotient shifting in}
  logic [63:0] acc_q,       acc_d;
  // |A| as multiplicand for MUL, |B| as divisor for DIV
  logic [31:0] op_q,        op_d;
  logic        neg_q,       neg_d;
  logic        is_div_q,    is_div_d;
  logic [31:0] res_q,       res_d;
  logic        exc_q,       exc_d;
  logic [31:0] result_q,    result_d;
  logic        exception_q, exception_d;
  logic        rdy_q,       rdy_d;

  // Shared datapath: add for MUL, subtract (x + ~y + 1) for DIV.
  logic        add_sub;
  logic [32:0] add_x;
  logic [32:0] add_y;
  logic [32:0] add_sum;

  logic [63:0] signed_acc;
  logic        mul_ovf;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    // -2^31 maps to 0x80000000, which is correct when read as unsigned.
    magnitude = v[31] ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    add_sub = (state_q == S_DIV);
    // DIV operates on the remainder after the left shift, i.e. acc[62:31].
    add_x   = {1'b0, (add_sub ? acc_q[62:31] : acc_q[63:32])};
    add_y   = {1'b0, op_q} ^ {33{add_sub}};
    add_sum = add_x + add_y + {32'd0, add_sub};
  end

  // Sign fix of the 64-bit magnitude. For divide only the low word is used,
  // and the low word of a 64-bit negate depends only on the low word.
  always_comb begin
    signed_acc = neg_q ? (~acc_q + 64'd1) : acc_q;
    // Product fits in signed 32 bits only if bits 63..31 are all equal.
    mul_ovf    = ~((&signed_acc[63:31]) | ~(|signed_acc[63:31]));
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    op_d        = op_q;
    neg_d       = neg_q;
    is_div_d    = is_div_q;
    res_d       = res_q;
    exc_d       = exc_q;
    result_d    = result_q;
    exception_d = exception_q;
    rdy_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          count_d  = 5'd0;
          neg_d    = data_operandA[31] ^ data_operandB[31];
          is_div_d = ~ctrl_MULT;
          if (ctrl_MULT) begin
            op_d    = magnitude(data_operandA);
            acc_d   = {32'd0, magnitude(data_operandB)};
            state_d = S_MUL;
          end else begin
            op_d  = magnitude(data_operandB);
            acc_d = {32'd0, magnitude(data_operandA)};
            if (data_operandB == 32'd0) begin
              res_d   = 32'd0;
              exc_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end
        end
      end

      S_MUL: begin
        if (acc_q[0]) begin
          // Carry out of the add becomes the new MSB after the right shift.
          acc_d = {add_sum, acc_q[31:1]};
        end else begin
          acc_d = {1'b0, acc_q[63:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_DIV: begin
        if (!add_sum[32]) begin
          acc_d = {add_sum[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        res_d = signed_acc[31:0];
        if (is_div_q) begin
          // A non-negated quotient of 2^31 only arises from -2^31 / -1.
          exc_d = ~neg_q & acc_q[31];
        end else begin
          exc_d = mul_ovf;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        result_d    = res_q;
        exception_d = exc_q;
        rdy_d       = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= 5'd0;
      acc_q       <= 64'd0;
      op_q        <= 32'd0;
      neg_q       <= 1'b0;
      is_div_q    <= 1'b0;
      res_q       <= 32'd0;
      exc_q       <= 1'b0;
      result_q    <= 32'd0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      is_div_q    <= is_div_d;
      res_q       <= res_d;
      exc_q       <= exc_d;
      result_q    <= result_d;
      exception_q <= exception_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exception_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
